// File: rtl/coh_req_arbiter.sv
//==============================================================================
// Module : coh_req_arbiter
// Orders per-source coherence requests onto a single bus, round-robin; build
// with PUTM_PRIO_EN to drain PUTM heads ahead of GETS/GETM.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module coh_req_arbiter #(
    parameter int NUM_SRC    = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 32
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [NUM_SRC-1:0]                        req_valid,
    output logic [NUM_SRC-1:0]                        req_ready,
    input  logic [NUM_SRC*ADDR_W-1:0]                 req_addr,
    input  logic [NUM_SRC*2-1:0]                      req_tx,
    output logic                                      bus_valid,
    input  logic                                      bus_ready,
    output logic [$clog2(NUM_SRC)-1:0]                bus_source,
    output logic [ADDR_W-1:0]                         bus_addr,
    output logic [1:0]                                bus_tx,
    output logic [NUM_SRC*($clog2(FIFO_DEPTH)+1)-1:0] fifo_occ
);

    localparam int SRC_W = $clog2(NUM_SRC);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [1:0] TX_PUTM = 2'd2;
    localparam logic [1:0] TX_IDLE = 2'd3;

    logic                r_active;
    logic [SRC_W-1:0]    r_rr_ptr;
    logic [NUM_SRC-1:0]  w_push;
    logic [NUM_SRC-1:0]  w_pop;
    logic [NUM_SRC-1:0]  w_nonempty;
    logic [NUM_SRC-1:0]  w_cand;
    logic [ADDR_W-1:0]   w_head_addr [NUM_SRC];
    logic [1:0]          w_head_tx   [NUM_SRC];
    logic                w_slot_free;
    logic                w_grant_valid;
    logic [SRC_W-1:0]    w_grant;

    // Holds req_ready low until the first clock edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
        end else begin
            r_active <= 1'b1;
        end
    end

    assign w_slot_free = !bus_valid || bus_ready;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [ADDR_W-1:0] r_mem_addr [FIFO_DEPTH];
        logic [1:0]        r_mem_tx   [FIFO_DEPTH];
        logic [PTR_W-1:0]  r_wr_ptr;
        logic [PTR_W-1:0]  r_rd_ptr;
        logic [OCC_W-1:0]  r_occ;

        assign req_ready[i]   = r_active && (r_occ < OCC_W'(FIFO_DEPTH));
        assign w_push[i]      = req_valid[i] && req_ready[i] && (req_tx[2*i +: 2] != TX_IDLE);
        assign w_pop[i]       = w_slot_free && w_grant_valid && (w_grant == SRC_W'(i));
        assign w_nonempty[i]  = (r_occ != '0);
        assign w_head_addr[i] = r_mem_addr[r_rd_ptr];
        assign w_head_tx[i]   = r_mem_tx[r_rd_ptr];
        assign fifo_occ[i*OCC_W +: OCC_W] = r_occ;

        always_ff @(posedge clk) begin
            if (w_push[i]) begin
                r_mem_addr[r_wr_ptr] <= req_addr[i*ADDR_W +: ADDR_W];
                r_mem_tx[r_wr_ptr]   <= req_tx[2*i +: 2];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_occ    <= '0;
            end else begin
                if (w_push[i]) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop[i]) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                if (w_push[i] && !w_pop[i]) begin
                    r_occ <= r_occ + 1'b1;
                end else if (!w_push[i] && w_pop[i]) begin
                    r_occ <= r_occ - 1'b1;
                end
            end
        end
    end

`ifdef PUTM_PRIO_EN
    logic [NUM_SRC-1:0] w_head_putm;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_putm
        assign w_head_putm[i] = w_nonempty[i] && (w_head_tx[i] == TX_PUTM);
    end

    // Evictions win whenever any head is a PUTM; same pointer either way.
    assign w_cand = (|w_head_putm) ? w_head_putm : w_nonempty;
`else
    assign w_cand = w_nonempty;
`endif

    always_comb begin
        w_grant_valid = 1'b0;
        w_grant       = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            logic [SRC_W-1:0] idx;
            idx = SRC_W'((int'(r_rr_ptr) + k) % NUM_SRC);
            if (!w_grant_valid && w_cand[idx]) begin
                w_grant_valid = 1'b1;
                w_grant       = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_valid  <= 1'b0;
            bus_source <= '0;
            bus_addr   <= '0;
            bus_tx     <= '0;
            r_rr_ptr   <= '0;
        end else if (w_slot_free) begin
            if (w_grant_valid) begin
                bus_valid  <= 1'b1;
                bus_source <= w_grant;
                bus_addr   <= w_head_addr[w_grant];
                bus_tx     <= w_head_tx[w_grant];
                r_rr_ptr   <= SRC_W'((int'(w_grant) + 1) % NUM_SRC);
            end else begin
                bus_valid  <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_coh_req_arbiter.sv
//==============================================================================
// Module : tb_coh_req_arbiter
// Self-checking bench for coh_req_arbiter against a queue-based reference model.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_coh_req_arbiter;

    localparam int N  = 8;
    localparam int D  = 4;
    localparam int AW = 32;
    localparam int OW = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*2-1:0]  req_tx;
    logic            bus_valid;
    logic            bus_ready;
    logic [2:0]      bus_source;
    logic [AW-1:0]   bus_addr;
    logic [1:0]      bus_tx;
    logic [N*OW-1:0] fifo_occ;

    int checks = 0;
    int errors = 0;

    // Reference model: one queue of {tx, addr} per source plus the issued slot.
    logic [33:0]   mq [N][$];
    int            m_ptr;
    bit            m_valid;
    bit            m_active;
    int            m_src;
    logic [31:0]   m_addr;
    logic [1:0]    m_tx;

    always #5 clk = ~clk;

    coh_req_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_tx     (req_tx),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .bus_source (bus_source),
        .bus_addr   (bus_addr),
        .bus_tx     (bus_tx),
        .fifo_occ   (fifo_occ)
    );

    function automatic int pick();
        bit use_putm = 1'b0;
        int s;
`ifdef PUTM_PRIO_EN
        for (int i = 0; i < N; i++) begin
            if (mq[i].size() > 0 && mq[i][0][33:32] == 2'd2) use_putm = 1'b1;
        end
`endif
        for (int k = 0; k < N; k++) begin
            s = (m_ptr + k) % N;
            if (mq[s].size() > 0 && (!use_putm || mq[s][0][33:32] == 2'd2)) return s;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) mq[i].delete();
        m_ptr = 0; m_valid = 1'b0; m_active = 1'b0;
        m_src = 0; m_addr = '0; m_tx = '0;
    endtask

    task automatic model_update();
        bit rdy [N];
        bit free;
        int g;
        free = !m_valid || bus_ready;
        for (int i = 0; i < N; i++) rdy[i] = m_active && (mq[i].size() < D);
        if (free) begin
            g = pick();
            if (g >= 0) begin
                {m_tx, m_addr} = mq[g].pop_front();
                m_src = g; m_valid = 1'b1; m_ptr = (g + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && rdy[i] && req_tx[2*i +: 2] != 2'd3)
                mq[i].push_back({req_tx[2*i +: 2], req_addr[i*AW +: AW]});
        end
        m_active = 1'b1;
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid = '0; req_addr = '0; req_tx = '0;
    endtask

    task automatic set_req(input int s, input logic [1:0] tx, input logic [31:0] a);
        req_valid[s] = 1'b1;
        req_tx[2*s +: 2] = tx;
        req_addr[s*AW +: AW] = a;
    endtask

    function automatic int occ_of(input int s);
        return int'(fifo_occ[s*OW +: OW]);
    endfunction

    task automatic release_reset();
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        step();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_inputs();
        bus_ready = 1'b0;
        #1;
        model_reset();
        release_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < N; i++) set_req(i, 2'd0, 32'h300 + i);
        step();
        clear_inputs();
        step();
        step();
        checks++;
        if (bus_valid !== 1'b1) begin errors++; $display("FAIL reset_pre_traffic: bus_valid=%0b want 1", bus_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (bus_valid !== 1'b0) begin errors++; $display("FAIL reset_async_valid: bus_valid=%0b want 0", bus_valid); end
        checks++;
        if (fifo_occ !== '0) begin errors++; $display("FAIL reset_occ: fifo_occ=%h want 0", fifo_occ); end
        checks++;
        if (req_ready !== '0) begin errors++; $display("FAIL reset_ready_low: req_ready=%b want 0", req_ready); end
        checks++;
        if (bus_source !== 3'd0 || bus_addr !== 32'd0 || bus_tx !== 2'd0) begin
            errors++; $display("FAIL reset_bus_fields: src=%0d addr=%h tx=%0d want 0", bus_source, bus_addr, bus_tx);
        end
        release_reset();
        checks++;
        if (req_ready !== {N{1'b1}}) begin errors++; $display("FAIL reset_ready_after: req_ready=%b want all 1", req_ready); end
        checks++;
        if (bus_valid !== 1'b0 || fifo_occ !== '0) begin
            errors++; $display("FAIL reset_after_state: bus_valid=%0b fifo_occ=%h want 0/0", bus_valid, fifo_occ);
        end
    endtask

    task automatic test_single();
        apply_reset();
        set_req(3, 2'd1, 32'h0000_1040);
        bus_ready = 1'b1;
        step();
        clear_inputs();
        checks++;
        if (bus_valid !== 1'b0) begin errors++; $display("FAIL single_latency: bus_valid=%0b want 0 one edge after push", bus_valid); end
        step();
        checks++;
        if (bus_valid !== 1'b1 || bus_source !== 3'd3 || bus_tx !== 2'd1 || bus_addr !== 32'h0000_1040) begin
            errors++;
            $display("FAIL single_issue: valid=%0b src=%0d tx=%0d addr=%h want 1/3/1/00001040",
                     bus_valid, bus_source, bus_tx, bus_addr);
        end
        bus_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (bus_valid !== 1'b1 || bus_source !== 3'd3 || bus_tx !== 2'd1 || bus_addr !== 32'h0000_1040) begin
                errors++;
                $display("FAIL single_hold: cycle=%0d valid=%0b src=%0d tx=%0d addr=%h want 1/3/1/00001040",
                         c, bus_valid, bus_source, bus_tx, bus_addr);
            end
        end
        bus_ready = 1'b1;
        step();
        checks++;
        if (bus_valid !== 1'b0) begin errors++; $display("FAIL single_drain: bus_valid=%0b want 0", bus_valid); end
    endtask

    task automatic test_fairness();
        apply_reset();
        for (int i = 0; i < N; i++) set_req(i, 2'd0, 32'h100 + i);
        step();
        clear_inputs();
        bus_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            step();
            checks++;
            if (bus_valid !== 1'b1 || bus_source !== 3'(k) || bus_addr !== 32'h100 + k || bus_tx !== 2'd0) begin
                errors++;
                $display("FAIL fair_order: slot=%0d valid=%0b src=%0d addr=%h want 1/%0d/%h",
                         k, bus_valid, bus_source, bus_addr, k, 32'h100 + k);
            end
        end
        step();
        checks++;
        if (bus_valid !== 1'b0) begin errors++; $display("FAIL fair_empty: bus_valid=%0b want 0", bus_valid); end
        set_req(5, 2'd0, 32'h505);
        set_req(2, 2'd0, 32'h202);
        step();
        clear_inputs();
        step();
        checks++;
        if (bus_valid !== 1'b1 || bus_source !== 3'd2 || bus_addr !== 32'h202) begin
            errors++; $display("FAIL fair_wrap_first: valid=%0b src=%0d addr=%h want 1/2/202", bus_valid, bus_source, bus_addr);
        end
        step();
        checks++;
        if (bus_valid !== 1'b1 || bus_source !== 3'd5 || bus_addr !== 32'h505) begin
            errors++; $display("FAIL fair_wrap_second: valid=%0b src=%0d addr=%h want 1/5/505", bus_valid, bus_source, bus_addr);
        end
    endtask

    task automatic test_full();
        bit exp_rdy;
        apply_reset();
        bus_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            clear_inputs();
            set_req(0, 2'd0, 32'h2000 + k);
            exp_rdy = m_active && (mq[0].size() < D);
            checks++;
            if (req_ready[0] !== exp_rdy) begin
                errors++; $display("FAIL full_ready: push=%0d req_ready0=%0b want %0b", k, req_ready[0], exp_rdy);
            end
            step();
        end
        clear_inputs();
        checks++;
        if (occ_of(0) != 4 || req_ready[0] !== 1'b0) begin
            errors++; $display("FAIL full_state: occ0=%0d ready0=%0b want 4/0", occ_of(0), req_ready[0]);
        end
        checks++;
        if (bus_valid !== 1'b1 || bus_addr !== 32'h2000) begin
            errors++; $display("FAIL full_head_held: valid=%0b addr=%h want 1/00002000", bus_valid, bus_addr);
        end
        bus_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            step();
            checks++;
            if (bus_valid !== 1'b1 || bus_source !== 3'd0 || bus_addr !== 32'h2000 + k) begin
                errors++;
                $display("FAIL full_drain_order: k=%0d valid=%0b src=%0d addr=%h want 1/0/%h",
                         k, bus_valid, bus_source, bus_addr, 32'h2000 + k);
            end
        end
        step();
        checks++;
        if (bus_valid !== 1'b0) begin errors++; $display("FAIL full_sixth_dropped: bus_valid=%0b addr=%h want 0", bus_valid, bus_addr); end
    endtask

    task automatic test_idle();
        apply_reset();
        bus_ready = 1'b1;
        set_req(1, 2'd3, 32'hDEAD_BEEF);
        checks++;
        if (req_ready[1] !== 1'b1) begin errors++; $display("FAIL idle_ready: req_ready1=%0b want 1", req_ready[1]); end
        step();
        clear_inputs();
        checks++;
        if (occ_of(1) != 0) begin errors++; $display("FAIL idle_occ: occ1=%0d want 0", occ_of(1)); end
        step();
        step();
        checks++;
        if (bus_valid !== 1'b0) begin errors++; $display("FAIL idle_no_issue: bus_valid=%0b want 0", bus_valid); end
    endtask

    task automatic test_putm_prio();
        int first;
        int second;
`ifdef PUTM_PRIO_EN
        first = 6; second = 0;
`else
        first = 0; second = 6;
`endif
        apply_reset();
        set_req(0, 2'd0, 32'hA000);
        set_req(6, 2'd2, 32'hA600);
        step();
        clear_inputs();
        bus_ready = 1'b1;
        step();
        checks++;
        if (bus_valid !== 1'b1 || int'(bus_source) != first) begin
            errors++; $display("FAIL putm_first: valid=%0b src=%0d want 1/%0d", bus_valid, bus_source, first);
        end
        step();
        checks++;
        if (bus_valid !== 1'b1 || int'(bus_source) != second) begin
            errors++; $display("FAIL putm_second: valid=%0b src=%0d want 1/%0d", bus_valid, bus_source, second);
        end
    endtask

    task automatic test_random();
        int push_pct;
        apply_reset();
        for (int c = 0; c < 800; c++) begin
            push_pct = (c < 500) ? 50 : 10;
            for (int i = 0; i < N; i++) begin
                req_valid[i] = ($urandom_range(0, 99) < push_pct);
                req_tx[2*i +: 2] = 2'($urandom_range(0, 3));
                req_addr[i*AW +: AW] = $urandom;
            end
            bus_ready = ($urandom_range(0, 3) != 0);
            step();
            checks++;
            if (bus_valid !== m_valid) begin
                errors++; $display("FAIL rand_valid: cycle=%0d bus_valid=%0b want %0b", c, bus_valid, m_valid);
            end
            if (m_valid) begin
                checks++;
                if (int'(bus_source) != m_src || bus_addr !== m_addr || bus_tx !== m_tx) begin
                    errors++;
                    $display("FAIL rand_bus: cycle=%0d src=%0d addr=%h tx=%0d want %0d/%h/%0d",
                             c, bus_source, bus_addr, bus_tx, m_src, m_addr, m_tx);
                end
            end
            for (int i = 0; i < N; i++) begin
                checks++;
                if (occ_of(i) != mq[i].size() || req_ready[i] !== (mq[i].size() < D)) begin
                    errors++;
                    $display("FAIL rand_fifo: cycle=%0d src=%0d occ=%0d ready=%0b want %0d/%0b",
                             c, i, occ_of(i), req_ready[i], mq[i].size(), mq[i].size() < D);
                end
            end
        end
    endtask

    initial begin
        clear_inputs();
        bus_ready = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_full();
        test_idle();
        test_putm_prio();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire
